// File: rtl/mul_approx_pkg.sv
// Shared types and helpers for the sequential approximate multiplier.
// Holds the FSM state encoding, mode constants and the column mask.
package mul_approx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_TRUNC = 1'b1;

  function automatic logic [63:0] mask_low(
    input logic [63:0] value,
    input int unsigned k
  );
    logic [63:0] keep;
    keep = (k >= 64) ? '0 : ~((64'd1 << k) - 64'd1);
    return value & keep;
  endfunction

endpackage

// File: rtl/approx_pp_gen.sv
// Partial-product generator for one shift-add iteration.
// Truncated mode drops the TRUNC_K low product columns.
module approx_pp_gen
  import mul_approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC_K = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [CNT_W-1:0]   idx,
  input  logic               mode,
  output logic [2*WIDTH-1:0] pp
);

  localparam logic [2*WIDTH-1:0] KEEP =
    (2*WIDTH)'(mask_low('1, TRUNC_K));

  logic [2*WIDTH-1:0] wide;

  assign wide = {{WIDTH{1'b0}}, a} << idx;

  always_comb begin
    pp = '0;
    if (b_bit) begin
      pp = (mode == MODE_TRUNC) ? (wide & KEEP) : wide;
    end
  end

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier, exact or column-truncated per operation.
// One partial product per cycle; valid/ready on both sides.
module approx_mul_seq
  import mul_approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC_K = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               mode_r;

  approx_pp_gen #(
    .WIDTH  (WIDTH),
    .TRUNC_K(TRUNC_K)
  ) u_pp (
    .a    (a_r),
    .b_bit(b_r[0]),
    .idx  (cnt),
    .mode (mode_r),
    .pp   (pp)
  );

  assign sum = acc + pp;

  // b is shifted right so the current multiplier bit is always b_r[0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      mode_r    <= MODE_EXACT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_mode  <= MODE_EXACT;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            mode_r   <= in_mode;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= sum;
          b_r <= b_r >> 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            out_p     <= sum;
            out_mode  <= mode_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed and random checks of approx_mul_seq at WIDTH 8 and 16.
// Expected products are queued on acceptance and compared on output.
module tb_approx_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v8, v16, ordy;
  logic [15:0] ia, ib;
  logic        im;
  logic        rdy8, ov8, om8;
  logic [15:0] p8;
  logic        rdy16, ov16, om16;
  logic [31:0] p16;

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [31:0] p;
    logic        m;
  } exp_t;
  exp_t q[$];

  approx_mul_seq #(.WIDTH(8), .TRUNC_K(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .in_a(ia[7:0]), .in_b(ib[7:0]), .in_mode(im),
    .out_valid(ov8), .out_ready(ordy),
    .out_p(p8), .out_mode(om8)
  );

  approx_mul_seq #(.WIDTH(16), .TRUNC_K(0)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(rdy16),
    .in_a(ia), .in_b(ib), .in_mode(im),
    .out_valid(ov16), .out_ready(ordy),
    .out_p(p16), .out_mode(om16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    input logic [31:0] a, input logic [31:0] b,
    input logic m, input int w, input int k
  );
    logic [63:0] s, pp;
    s = '0;
    for (int i = 0; i < w; i++) begin
      if (b[i]) begin
        pp = 64'(a) << i;
        if (m) pp = pp & ~((64'd1 << k) - 64'd1);
        s = s + pp;
      end
    end
    if (w < 32) s = s & ((64'd1 << (2 * w)) - 64'd1);
    return s[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit w, input logic [15:0] a,
                       input logic [15:0] b, input logic m,
                       input logic [31:0] p);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", w ? rdy16 : rdy8, 1);
    ia = a; ib = b; im = m;
    if (w) v16 = 1'b1; else v8 = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    v8 = 1'b0; v16 = 1'b0;
    e.p = p; e.m = m;
    q.push_back(e);
  endtask

  task automatic wait_out(input bit w);
    int n;
    exp_t e;
    n = 0;
    while (!(w ? ov16 : ov8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_seen", w ? ov16 : ov8, 1);
    chk("latency", cyc - acc_cyc, w ? 16 : 8);
    if (q.size() == 0) begin
      chk("queue_nonempty", 0, 1);
    end else begin
      e = q.pop_front();
      chk("out_p", w ? p16 : {16'h0, p8}, e.p);
      chk("out_mode", w ? om16 : om8, e.m);
    end
  endtask

  task automatic finish_xfer(input bit w);
    @(posedge clk); #1;
    chk("xfer_done", w ? ov16 : ov8, 0);
    chk("ready_back", w ? rdy16 : rdy8, 1);
  endtask

  task automatic op(input bit w, input logic [15:0] a,
                    input logic [15:0] b, input logic m,
                    input logic [31:0] p);
    start(w, a, b, m, p);
    wait_out(w);
    finish_xfer(w);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rm;
    rst_n = 1'b0; v8 = 1'b0; v16 = 1'b0; ordy = 1'b1;
    ia = '0; ib = '0; im = 1'b0;
    #12;
    chk("rst_in_ready", rdy8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_out_p", p8, 0);
    chk("rst_out_mode", om8, 0);
    @(negedge clk) rst_n = 1'b1;

    op(0, 255, 255, 0, 32'd65025);
    op(0, 255, 255, 1, 32'd64976);
    op(0, 3, 5, 1, 32'd0);
    op(0, 3, 5, 0, 32'd15);

    // backpressure with an ignored in_valid pulse
    ordy = 1'b0;
    start(0, 7, 9, 0, 32'd63);
    wait_out(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin ia = 16'd1; ib = 16'd1; v8 = 1'b1; end
      else v8 = 1'b0;
      @(posedge clk); #1;
      chk("bp_valid", ov8, 1);
      chk("bp_p", p8, 63);
      chk("bp_ready", rdy8, 0);
    end
    @(negedge clk) ordy = 1'b1;
    finish_xfer(0);
    repeat (12) @(posedge clk);
    #1 chk("bp_no_extra", ov8, 0);

    // operands disturbed while busy
    start(0, 12, 10, 0, 32'd120);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ia = 16'($urandom); ib = 16'($urandom); im = 1'b1; v8 = 1'b1;
    end
    @(negedge clk) v8 = 1'b0;
    wait_out(0);
    finish_xfer(0);

    // reset in the middle of an operation
    start(0, 200, 100, 0, 32'd20000);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_valid", ov8, 0);
    chk("abort_ready", rdy8, 1);
    chk("abort_p", p8, 0);
    chk("abort_mode", om8, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("abort_no_out", ov8, 0);

    op(1, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001);
    op(1, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001);

    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rm = 1'($urandom);
      op(0, ra, rb, rm, model(32'(ra), 32'(rb), rm, 8, 4));
    end
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      op(1, ra, rb, rm, model(32'(ra), 32'(rb), rm, 16, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
